adc_avg_acquire: RTL
====================

// Module: adc_avg_acquire
// PURPOSE
//  Multi-channel successor of the single-channel ADC acquire/average block.
//  On a syncro_i rising edge, runs one frame: for channel 0..N_CH-1 in order, takes 2**AVG_LOG2 ADC samples,
//  then outputs each channel's rounded signed mean with a one-cycle strobe.
//  Sits between the external ADC handshake and downstream DSP; adds a conversion timeout and error flag.
// PARAMETERS
//  DATA_W   12   ADC sample / result width, two's complement
//  N_CH     4    channels per frame (>=1)
//  AVG_LOG2 3    log2 of samples averaged per channel (>=1)
//  TMO_CYC  255  max cycles from req to conversion done before abort
// PORTS
//  clk_i          in   1                 system clock, rising edge
//  reset_n_i      in   1                 asynchronous active-low reset
//  adc_data_req_o out  1                 1-cycle conversion request pulse
//  adc_ch_o       out  $clog2(N_CH)|1    channel to convert, stable from req to sample
//  adc_data_rdy_i in   1                 ADC ready: low = converting, rising back high = data valid
//  adc_data_i     in   DATA_W            signed ADC sample, valid while rdy high after busy
//  syncro_i       in   1                 frame start, rising-edge sensitive
//  data_o         out  DATA_W            signed channel average
//  data_ch_o      out  $clog2(N_CH)|1    channel of data_o
//  data_rdy_o     out  1                 1-cycle strobe, data_o/data_ch_o valid
//  busy_o         out  1                 high from frame start to frame end/abort
//  err_o          out  1                 1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, accumulator/counters cleared; reset mid-frame abandons the frame, no strobe.
//  All inputs synchronous to clk_i. syncro edge: registered syncro_i vs current value.
//  FSM: IDLE -(syncro rise)-> REQ -> WAIT_BUSY -(rdy=0)-> WAIT_DONE -(rdy=1)-> ACC -> REQ | OUT; OUT -> REQ | IDLE.
//  REQ: adc_data_req_o=1 for exactly one cycle; timeout counter cleared.
//  WAIT_DONE rdy=1: adc_data_i added to the accumulator that cycle (sign-extended into a DATA_W+AVG_LOG2 bit accumulator).
//  ACC: sample counter++; if < 2**AVG_LOG2 -> REQ, else -> OUT.
//  OUT: data_o = (acc + 2**(AVG_LOG2-1)) >>> AVG_LOG2 (round half up); data_rdy_o=1, data_ch_o=channel.
//   Then acc cleared, channel++; last channel -> IDLE (busy_o drops same edge), else -> REQ.
//  data_o holds its value until the next OUT.
//  Strobe is 2 cycles after the final sample clocks into the accumulator.
//  Result never overflows DATA_W (mean bounded by input range).
//  syncro_i rise while busy_o=1 is ignored, not queued.
//  Timeout: WAIT_BUSY+WAIT_DONE cycles reach TMO_CYC -> err_o pulse; no strobe for that channel; frame aborts to IDLE.
//  rdy already low at REQ+1 is accepted as busy (zero-latency ADC).
// CONFIGURATION
//  ADC_AVG_CONT_EN defined: after last channel OUT, FSM returns to REQ ch0 (free-running); busy_o stays 1.
//   A syncro_i rise restarts the frame at ch0 with a cleared accumulator. Timeout abort still goes to IDLE.
//  Undefined: single frame per syncro_i rise, as above.
// STRUCTURE
//  adc_acq_pkg: state enum (IDLE,REQ,WAIT_BUSY,WAIT_DONE,ACC,OUT), width localparams
//   (ACC_W=DATA_W+AVG_LOG2, CH_W), rounding constant.
//  Sub-module adc_avg_accum: clear/add/round-out datapath (acc register + rounding shifter);
//   FSM, counters and timeout stay in top.
// TESTING
//  Default params, ch0 samples 20,-15,32,2,-36,52,5,2 (busy 15 cyc each) -> data_o=8 (0x008), data_ch_o=0.
//  Rounding: eight samples -3 (sum -24) -> -3; sum -20 -> -2 (0xFFE); sum 4 -> 1.
//  N_CH=4, ch k constant 100*k -> four strobes, ch 0..3 values 0,100,200,300, busy_o falls with last.
//  Extremes: all samples 0x7FF -> 0x7FF; all 0x800 -> 0x800, no wrap.
//  ADC holds rdy low > TMO_CYC on ch1 -> err_o pulse, no ch1 strobe, busy_o=0, next syncro_i starts at ch0.
//  syncro_i pulsed mid-frame ignored; reset_n_i low mid-WAIT_DONE -> all outputs 0 immediately.
//  ADC_AVG_CONT_EN: frames repeat without syncro_i.

Source files
------------

// File: rtl/adc_acq_pkg.sv
// Shared types, state encoding and width helpers for the multi-channel ADC averaging block.
// Default parameter values live here so the interface, top and datapath agree on them.
package adc_acq_pkg;

    localparam int DATA_W_DEF   = 12;
    localparam int N_CH_DEF     = 4;
    localparam int AVG_LOG2_DEF = 3;
    localparam int TMO_CYC_DEF  = 255;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_REQ       = 3'd1;
    localparam state_t S_WAIT_BUSY = 3'd2;
    localparam state_t S_WAIT_DONE = 3'd3;
    localparam state_t S_ACC       = 3'd4;
    localparam state_t S_OUT       = 3'd5;

    function automatic int acc_width(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

    // A single-channel build still needs a one-bit channel field.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Half an LSB of the mean, added before the shift for round-half-up.
    function automatic int round_const(input int avg_log2);
        return 1 << (avg_log2 - 1);
    endfunction

    localparam int ACC_W_DEF = acc_width(DATA_W_DEF, AVG_LOG2_DEF);
    localparam int CH_W_DEF  = ch_width(N_CH_DEF);

endpackage

// File: rtl/adc_avg_acquire_if.sv
// ADC handshake, frame trigger and averaged-result bus of adc_avg_acquire.
// master = the averaging block, slave = the ADC / frame source / downstream side.
interface adc_avg_acquire_if
    import adc_acq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_CH   = N_CH_DEF
) ();

    localparam int CH_W = ch_width(N_CH);

    logic              adc_data_req_o;
    logic [CH_W-1:0]   adc_ch_o;
    logic              adc_data_rdy_i;
    logic [DATA_W-1:0] adc_data_i;
    logic              syncro_i;
    logic [DATA_W-1:0] data_o;
    logic [CH_W-1:0]   data_ch_o;
    logic              data_rdy_o;
    logic              busy_o;
    logic              err_o;

    modport master (
        output adc_data_req_o, adc_ch_o, data_o, data_ch_o, data_rdy_o, busy_o, err_o,
        input  adc_data_rdy_i, adc_data_i, syncro_i
    );

    modport slave (
        input  adc_data_req_o, adc_ch_o, data_o, data_ch_o, data_rdy_o, busy_o, err_o,
        output adc_data_rdy_i, adc_data_i, syncro_i
    );

endinterface

// File: rtl/adc_avg_accum.sv
// Signed sample accumulator with a round-half-up mean output (acc + half LSB) >>> AVG_LOG2.
// The accumulator is AVG_LOG2 bits wider than a sample, so the sum of 2**AVG_LOG2 samples never wraps.
module adc_avg_accum
    import adc_acq_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              clear,
    input  logic              add,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] mean
);

    localparam int             ACC_W = acc_width(DATA_W, AVG_LOG2);
    localparam logic [ACC_W-1:0] RND = ACC_W'(round_const(AVG_LOG2));

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] sample_ext;
    logic [ACC_W-1:0] rounded;

    genvar gi;
    generate
        for (gi = 0; gi < ACC_W; gi++) begin : g_ext
            if (gi < DATA_W) begin : g_data
                assign sample_ext[gi] = sample[gi];
            end else begin : g_sign
                assign sample_ext[gi] = sample[DATA_W-1];
            end
        end
    endgenerate

    always_comb begin
        acc_next = acc_reg;
        if (clear) begin
            acc_next = '0;
        end else if (add) begin
            acc_next = acc_reg + sample_ext;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    // Taking the top DATA_W bits is the arithmetic shift; the mean cannot exceed the sample range.
    assign rounded = acc_reg + RND;
    assign mean    = rounded[ACC_W-1 -: DATA_W];

endmodule

// File: rtl/adc_avg_acquire.sv
// Multi-channel ADC acquire/average: per frame, averages 2**AVG_LOG2 samples per channel and strobes each mean.
// Define ADC_AVG_CONT_EN for free-running frames (syncro_i rise restarts at channel 0).
module adc_avg_acquire
    import adc_acq_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int N_CH     = N_CH_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF,
    parameter int TMO_CYC  = TMO_CYC_DEF
) (
    input logic               clk_i,
    input logic               reset_n_i,
    adc_avg_acquire_if.master bus
);

    localparam int CH_W  = ch_width(N_CH);
    localparam int TMO_W = $clog2(TMO_CYC + 1);

`ifdef ADC_AVG_CONT_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    state_t              state_reg;
    state_t              state_next;
    logic                syncro_reg;
    logic [CH_W-1:0]     ch_reg;
    logic [AVG_LOG2-1:0] smp_reg;
    logic [TMO_W-1:0]    tmo_reg;
    logic                req_reg;
    logic                busy_reg;
    logic                err_reg;
    logic                data_rdy_reg;
    logic [DATA_W-1:0]   data_reg;
    logic [CH_W-1:0]     data_ch_reg;

    logic              syncro_rise;
    logic              start;
    logic              restart;
    logic              abort;
    logic              waiting;
    logic              tmo_expire;
    logic              ch_last;
    logic              smp_last;
    logic              acc_clear;
    logic              acc_add;
    logic [DATA_W-1:0] mean;

    assign syncro_rise = bus.syncro_i & ~syncro_reg;
    assign start       = (state_reg == S_IDLE) && syncro_rise;
    assign waiting     = (state_reg == S_WAIT_BUSY) || (state_reg == S_WAIT_DONE);
    assign tmo_expire  = (tmo_reg == TMO_W'(TMO_CYC - 1));
    assign ch_last     = (ch_reg == CH_W'(N_CH - 1));
    assign smp_last    = &smp_reg;

    // Abort only on a waiting cycle that makes no progress; a late conversion on the last cycle still counts.
    assign abort = tmo_expire &&
                   (((state_reg == S_WAIT_BUSY) &&  bus.adc_data_rdy_i) ||
                    ((state_reg == S_WAIT_DONE) && !bus.adc_data_rdy_i));

    assign restart = CONT_EN && syncro_rise && (state_reg != S_IDLE) && !abort;

    always_comb begin
        state_next = state_reg;
        acc_clear  = 1'b0;
        acc_add    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (syncro_rise) begin
                    state_next = S_REQ;
                    acc_clear  = 1'b1;
                end
            end
            S_REQ:       state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!bus.adc_data_rdy_i) begin
                    state_next = S_WAIT_DONE;
                end else if (abort) begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.adc_data_rdy_i) begin
                    state_next = S_ACC;
                    acc_add    = 1'b1;
                end else if (abort) begin
                    state_next = S_IDLE;
                end
            end
            S_ACC:       state_next = smp_last ? S_OUT : S_REQ;
            S_OUT: begin
                acc_clear  = 1'b1;
                state_next = (ch_last && !CONT_EN) ? S_IDLE : S_REQ;
            end
            default:     state_next = S_IDLE;
        endcase
        if (restart) begin
            state_next = S_REQ;
            acc_clear  = 1'b1;
            acc_add    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg    <= S_IDLE;
            syncro_reg   <= 1'b0;
            ch_reg       <= '0;
            smp_reg      <= '0;
            tmo_reg      <= '0;
            req_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            data_rdy_reg <= 1'b0;
            data_reg     <= '0;
            data_ch_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            syncro_reg   <= bus.syncro_i;
            req_reg      <= (state_next == S_REQ);
            busy_reg     <= (state_next != S_IDLE);
            err_reg      <= abort;
            data_rdy_reg <= (state_reg == S_OUT) && !restart;

            if ((state_reg == S_OUT) && !restart) begin
                data_reg    <= mean;
                data_ch_reg <= ch_reg;
            end

            if (state_next == S_REQ) begin
                tmo_reg <= '0;
            end else if (waiting) begin
                tmo_reg <= tmo_reg + TMO_W'(1);
            end

            // The sample counter wraps to zero after the last sample of a channel.
            if (start || restart || abort) begin
                smp_reg <= '0;
            end else if (state_reg == S_ACC) begin
                smp_reg <= smp_reg + AVG_LOG2'(1);
            end

            if (start || restart || abort) begin
                ch_reg <= '0;
            end else if (state_reg == S_OUT) begin
                ch_reg <= ch_last ? '0 : ch_reg + CH_W'(1);
            end
        end
    end

    adc_avg_accum #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear     (acc_clear),
        .add       (acc_add),
        .sample    (bus.adc_data_i),
        .mean      (mean)
    );

    assign bus.adc_data_req_o = req_reg;
    assign bus.adc_ch_o       = ch_reg;
    assign bus.data_o         = data_reg;
    assign bus.data_ch_o      = data_ch_reg;
    assign bus.data_rdy_o     = data_rdy_reg;
    assign bus.busy_o         = busy_reg;
    assign bus.err_o          = err_reg;

endmodule
